vtdl_fifo_ctrl: RTL

VTDL_FIFO_CTRL -- requirements
Module: vtdl_fifo_ctrl

---
 rtl/vtdl_fifo_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/vtdl_fifo_ctrl.sv
// FIFO controller that keeps its data in an external shift-type delay line.
// Optional watermark flag (wmark_i / wmark_o) is compiled in with VTDL_FIFO_WMARK_EN.
module vtdl_fifo_ctrl #(
  parameter  int WID = 8,
  parameter  int DEP = 16,
  localparam int AW  = $clog2(DEP)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
  input  logic           wvalid_i,
  input  logic [WID-1:0] wdata_i,
  output logic           wready_o,
  output logic           rvalid_o,
  output logic [WID-1:0] rdata_o,
  input  logic           rready_i,
  output logic           dl_ce_o,
  output logic [WID-1:0] dl_d_o,
  output logic [AW-1:0]  dl_a_o,
  input  logic [WID-1:0] dl_q_i,
`ifdef VTDL_FIFO_WMARK_EN
  input  logic [AW:0]    wmark_i,
  output logic           wmark_o,
`endif
  output logic [AW:0]    count_o,
  output logic           full_o,
  output logic           empty_o
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [AW:0] DEP_C = (AW+1)'(DEP);
  localparam logic [AW:0] ONE_C = {{AW{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic   [AW:0]   count_q, count_d;
  logic   [AW:0]   count_m1_s;
  logic            run_s, push_s, pop_s;

  // State and occupancy registers; reset wins over flush and traffic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Handshakes, delay-line control and next-state/next-count logic.
  always_comb begin
    run_s      = (state_q == RUN);
    full_o     = (count_q == DEP_C);
    empty_o    = (count_q == '0);
    rvalid_o   = run_s & ~empty_o;
    pop_s      = rvalid_o & rready_i;
    wready_o   = run_s & (~full_o | pop_s);
    push_s     = wvalid_i & wready_o;
    dl_ce_o    = push_s;
    dl_d_o     = wdata_i;
    count_m1_s = count_q - ONE_C;
    // The oldest entry always sits at index count-1 of the shift line.
    if (empty_o) begin
      dl_a_o = '0;
    end else begin
      dl_a_o = count_m1_s[AW-1:0];
    end
    rdata_o = dl_q_i;
    count_o = count_q;
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      RUN: begin
        if (flush_i) begin
          state_d = FLUSH;
          count_d = '0;
        end else if (push_s && !pop_s) begin
          count_d = count_q + ONE_C;
        end else if (pop_s && !push_s) begin
          count_d = count_m1_s;
        end else begin
          count_d = count_q;
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
        count_d = '0;
      end
    endcase
  end

`ifdef VTDL_FIFO_WMARK_EN
  logic wmark_q, wmark_d;

  // Watermark flag tracks the count that will be held next cycle.
  always_comb begin
    wmark_d = (count_d >= wmark_i);
    wmark_o = wmark_q;
  end

  // Watermark register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wmark_q <= 1'b0;
    end else begin
      wmark_q <= wmark_d;
    end
  end
`endif

endmodule
